// File: rtl/mult_11s_x_8s_if.sv
// Operand/result bundle for the 11x8 signed multiplier.
// The master side drives the operands and observes the product.
interface mult_11s_x_8s_if;
    logic signed [10:0] n1;
    logic signed [7:0]  n2;
    logic signed [18:0] result;

    modport master (
        output n1,
        output n2,
        input  result
    );

    modport slave (
        input  n1,
        input  n2,
        output result
    );
endinterface

// File: rtl/mult_11s_x_8s.sv
// Three-stage pipelined 11-bit x 8-bit two's-complement multiplier.
// Eight shifted copies of the sign-extended multiplicand are summed with
// ripple-carry adders. The n2[7] row carries negative weight and is
// subtracted as inverted bits plus a carry-in of one.
module mult_11s_x_8s (
    input  logic          clk,
    input  logic          rst,
    mult_11s_x_8s_if.slave bus
);

    localparam int PROD_W = 19;
    localparam int N1_W   = 11;
    localparam int N2_W   = 8;

    // Ripple-carry adder assembled from explicit full-adder cells.
    function automatic logic [PROD_W-1:0] rca(
        input logic [PROD_W-1:0] a,
        input logic [PROD_W-1:0] b,
        input logic              cin
    );
        logic [PROD_W-1:0] s;
        logic              c;
        c = cin;
        for (int i = 0; i < PROD_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        return s;
    endfunction

    logic signed [N1_W-1:0]   n1_p0;
    logic signed [N2_W-1:0]   n2_p0;
    logic signed [PROD_W-1:0] psum_p1 [4];
    logic signed [PROD_W-1:0] sum_p2;

    logic signed [PROD_W-1:0] n1x;
    logic signed [PROD_W-1:0] pp [N2_W];
    logic signed [PROD_W-1:0] lvl1 [4];
    logic signed [PROD_W-1:0] lvl2 [2];
    logic signed [PROD_W-1:0] lvl3;

    assign n1x = {{(PROD_W-N1_W){n1_p0[N1_W-1]}}, n1_p0};

    // S1 -> S2: partial-product rows; the top row is pre-inverted for subtraction.
    always_comb begin
        for (int i = 0; i < N2_W-1; i++) begin
            pp[i] = n2_p0[i] ? (n1x << i) : '0;
        end
        pp[N2_W-1] = n2_p0[N2_W-1] ? ~(n1x << (N2_W-1)) : '0;
    end

    // First reduction level: pair up rows; the last pair absorbs the +1 of the negation.
    always_comb begin
        lvl1[0] = rca(pp[0], pp[1], 1'b0);
        lvl1[1] = rca(pp[2], pp[3], 1'b0);
        lvl1[2] = rca(pp[4], pp[5], 1'b0);
        lvl1[3] = rca(pp[6], pp[7], n2_p0[N2_W-1]);
    end

    // S2 -> S3: remaining two reduction levels down to the final product.
    always_comb begin
        lvl2[0] = rca(psum_p1[0], psum_p1[1], 1'b0);
        lvl2[1] = rca(psum_p1[2], psum_p1[3], 1'b0);
        lvl3    = rca(lvl2[0], lvl2[1], 1'b0);
    end

    // Pipeline registers; reset clears every stage so in-flight products are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            n1_p0  <= '0;
            n2_p0  <= '0;
            for (int i = 0; i < 4; i++) begin
                psum_p1[i] <= '0;
            end
            sum_p2 <= '0;
        end else begin
            n1_p0  <= bus.n1;
            n2_p0  <= bus.n2;
            for (int i = 0; i < 4; i++) begin
                psum_p1[i] <= lvl1[i];
            end
            sum_p2 <= lvl3;
        end
    end

    assign bus.result = sum_p2;

endmodule

// File: tb/tb_mult_11s_x_8s.sv
// Bench for mult_11s_x_8s: directed corner products, streaming, mid-stream
// reset and a long random run against an integer-arithmetic reference.
module tb_mult_11s_x_8s;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    // Expected outputs: product sampled at this edge, one edge ago, two edges ago.
    logic [18:0] d0, d1, d2;

    mult_11s_x_8s_if bus ();

    mult_11s_x_8s dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] ref_prod(input logic [10:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[18:0];
    endfunction

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: result=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one operand pair (or reset) across one rising edge, then settle.
    task automatic step(input logic r, input logic [10:0] a, input logic [7:0] b);
        rst    = r;
        bus.n1 = a;
        bus.n2 = b;
        @(posedge clk);
        if (r) begin
            d0 = '0;
            d1 = '0;
            d2 = '0;
        end else begin
            d2 = d1;
            d1 = d0;
            d0 = ref_prod(a, b);
        end
        #1;
    endtask

    logic [10:0] da [14] = '{11'h555, 11'h2AA, 11'h555, 11'h7FF, 11'h7FF, 11'h555, 11'h2AA,
                             11'h7FF, 11'h7FF, 11'h000, 11'h000, 11'h400, 11'h400, 11'h3FF};
    logic [7:0]  db [14] = '{8'h55, 8'hAA, 8'hFF, 8'h80, 8'h81, 8'h81, 8'h81,
                             8'h7F, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h7F, 8'h7F};
    logic [18:0] dr [14] = '{19'h71D39, 19'h71AE4, 19'h002AB, 19'h00080, 19'h0007F, 19'h152D5, 19'h6ADAA,
                             19'h7FF81, 19'h00000, 19'h00000, 19'h00000, 19'h20000, 19'h60400, 19'h1FB81};

    initial begin
        tests  = 0;
        fails  = 0;
        d0     = '0;
        d1     = '0;
        d2     = '0;
        rst    = 1'b1;
        bus.n1 = '0;
        bus.n2 = '0;

        // Reset for two edges with nonzero operands present.
        step(1'b1, 11'h7FF, 8'h80);
        step(1'b1, 11'h3FF, 8'h7F);
        check("reset", bus.result, 19'h00000);

        // Zeros held after reset release while no real product has arrived.
        step(1'b0, 11'h000, 8'h00);
        check("post_reset_hold", bus.result, 19'h00000);

        // Directed pairs streamed back to back, then flushed.
        for (int j = 0; j < 16; j++) begin
            if (j < 14) step(1'b0, da[j], db[j]);
            else        step(1'b0, 11'h000, 8'h00);
            check("stream_model", bus.result, d2);
            if (j >= 2) check($sformatf("directed_%0d", j-2), bus.result, dr[j-2]);
        end

        // Mid-stream reset with three products in flight.
        step(1'b0, 11'h7FF, 8'h80);
        step(1'b0, 11'h400, 8'h80);
        step(1'b0, 11'h3FF, 8'h7F);
        check("pre_reset_out", bus.result, 19'h00080);
        step(1'b1, 11'h400, 8'h7F);
        check("midrst_clear", bus.result, 19'h00000);
        step(1'b0, 11'h555, 8'h55);
        check("midrst_drop1", bus.result, 19'h00000);
        step(1'b0, 11'h000, 8'h00);
        check("midrst_drop2", bus.result, 19'h00000);
        step(1'b0, 11'h000, 8'h00);
        check("midrst_next", bus.result, 19'h71D39);
        step(1'b0, 11'h000, 8'h00);
        check("midrst_tail", bus.result, 19'h00000);

        // Random streaming run.
        for (int k = 0; k < 10000; k++) begin
            step(1'b0, 11'($urandom), 8'($urandom));
            check("random", bus.result, d2);
        end
        step(1'b0, 11'h000, 8'h00);
        check("random_drain1", bus.result, d2);
        step(1'b0, 11'h000, 8'h00);
        check("random_drain2", bus.result, d2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
